// File: rtl/nlc_format_converter.sv
// nlc_format_converter
//   Fully pipelined bidirectional sample-format converter, no backpressure.
//   mode 0: INT_W-bit two's-complement ADC code (din[INT_W-1:0]) -> IEEE-754 single (exact).
//   mode 1: IEEE-754 single -> INT_W-bit integer, round-half-away-from-zero,
//           clamped to the INT_W range; NaN gives 0. Result sign-extended to 32 bits.
//   One result per accepted input, LAT=3 cycles after the sampling edge.
//
// Ports
//   clk      in   sole clock, rising edge
//   rst      in   asynchronous reset, active low
//   srdyi    in   input valid
//   mode     in   conversion direction (0: int->fp, 1: fp->int)
//   tag_i    in   channel tag, travels with the sample
//   din      in   input sample
//   srdyo    out  output valid (one cycle per accepted input)
//   dout     out  converted sample, held while srdyo=0
//   tag_o    out  tag of dout
//   mode_o   out  mode of dout
//   sat_o    out  mode-1 result clamped or NaN input
//   sat_cnt  out  number of saturated results, sticks at 255
module nlc_format_converter #(
  parameter int unsigned INT_W = 21,
  parameter int unsigned LAT   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        srdyi,
  input  logic        mode,
  input  logic [3:0]  tag_i,
  input  logic [31:0] din,
  output logic        srdyo,
  output logic [31:0] dout,
  output logic [3:0]  tag_o,
  output logic        mode_o,
  output logic        sat_o,
  output logic [7:0]  sat_cnt
);

  localparam int unsigned P_W   = $clog2(INT_W);
  localparam int unsigned SH_W  = 5;
  localparam int unsigned SIG_W = 24;
  localparam int unsigned SUM_W = 26;
  // Smallest biased exponent whose magnitude (>= 2^INT_W) always clamps.
  localparam logic [7:0]  EXP_OVF = 8'(127 + INT_W);
  localparam logic [INT_W-1:0] INT_MAX_V = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] INT_MIN_V = {1'b1, {(INT_W-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Valid shift chain: bit 0 = stage 1 (input capture), bit LAT-1 = last stage
  // before the output register.
  logic [LAT-1:0] vld_q, vld_d;

  // Stage 1: raw input capture
  logic        s1_mode_q;
  logic [3:0]  s1_tag_q;
  logic [31:0] s1_din_q;

  // Stage 2: decoded fields for both directions
  logic             s2_mode_q;
  logic [3:0]       s2_tag_q;
  logic             s2_m0_sign_q, s2_m0_sign_d;
  logic [INT_W-1:0] s2_m0_mag_q,  s2_m0_mag_d;
  logic [P_W-1:0]   s2_m0_msb_q,  s2_m0_msb_d;
  logic             s2_m1_sign_q, s2_m1_sign_d;
  logic             s2_m1_nan_q,  s2_m1_nan_d;
  logic             s2_m1_ovf_q,  s2_m1_ovf_d;
  logic             s2_m1_zero_q, s2_m1_zero_d;
  logic [SIG_W-1:0] s2_m1_sig_q,  s2_m1_sig_d;
  logic [SH_W-1:0]  s2_m1_sh_q,   s2_m1_sh_d;

  // Stage 3: final result
  logic        s3_mode_q;
  logic [3:0]  s3_tag_q;
  logic [31:0] s3_dout_q, s3_dout_d;
  logic        s3_sat_q,  s3_sat_d;

  // Output registers
  logic        srdyo_q;
  logic [31:0] dout_q;
  logic [3:0]  tag_o_q;
  logic        mode_o_q;
  logic        sat_o_q;
  logic [7:0]  sat_cnt_q, sat_cnt_d;

  assign vld_d = {vld_q[LAT-2:0], srdyi};

  // Stage 2 decode: int magnitude + leading-one position, float field split.
  logic [INT_W-1:0] m0_int;
  logic [7:0]       f_exp;
  logic [22:0]      f_man;

  always_comb begin
    m0_int       = s1_din_q[INT_W-1:0];
    s2_m0_sign_d = m0_int[INT_W-1];
    s2_m0_mag_d  = s2_m0_sign_d ? (~m0_int + INT_W'(1)) : m0_int;
    s2_m0_msb_d  = '0;
    for (int i = 0; i < int'(INT_W); i++) begin
      if (s2_m0_mag_d[i]) s2_m0_msb_d = P_W'(i);
    end

    f_exp        = s1_din_q[30:23];
    f_man        = s1_din_q[22:0];
    s2_m1_sign_d = s1_din_q[31];
    s2_m1_nan_d  = (f_exp == 8'hFF) && (f_man != '0);
    // Inf lands here too since 255 >= EXP_OVF.
    s2_m1_ovf_d  = !s2_m1_nan_d && (f_exp >= EXP_OVF);
    // Exponent below 126 means |x| < 0.5 (covers zero and denormals).
    s2_m1_zero_d = (f_exp < 8'd126);
    s2_m1_sig_d  = {1'b1, f_man};
    // Right shift that leaves the integer part of sig * 2^(exp-150).
    s2_m1_sh_d   = SH_W'(8'd150 - f_exp);
  end

  // Stage 3 compute: float assembly (mode 0) or round + clamp (mode 1).
  logic [22:0]      m0_man;
  logic [7:0]       m0_exp;
  logic [SUM_W-1:0] m1_sum;
  logic [SUM_W-1:0] m1_rnd;
  logic [INT_W-1:0] m1_res;
  logic             m1_sat;

  always_comb begin
    m0_man = 23'(24'(s2_m0_mag_q) << (P_W'(23) - s2_m0_msb_q));
    m0_exp = 8'd127 + 8'(s2_m0_msb_q);

    // Adding half an LSB before truncation gives ties-away-from-zero on magnitude.
    m1_sum = SUM_W'(s2_m1_sig_q) + (SUM_W'(1) << (s2_m1_sh_q - SH_W'(1)));
    m1_rnd = m1_sum >> s2_m1_sh_q;
    m1_res = '0;
    m1_sat = 1'b0;
    if (s2_m1_nan_q) begin
      m1_sat = 1'b1;
    end else if (s2_m1_zero_q) begin
      m1_res = '0;
    end else if (s2_m1_ovf_q) begin
      m1_res = s2_m1_sign_q ? INT_MIN_V : INT_MAX_V;
      m1_sat = 1'b1;
    end else if (!s2_m1_sign_q && (m1_rnd > SUM_W'(INT_MAX_V))) begin
      m1_res = INT_MAX_V;
      m1_sat = 1'b1;
    end else if (s2_m1_sign_q && (m1_rnd > SUM_W'(INT_MIN_V))) begin
      m1_res = INT_MIN_V;
      m1_sat = 1'b1;
    end else begin
      m1_res = s2_m1_sign_q ? INT_W'(SUM_W'(0) - m1_rnd) : INT_W'(m1_rnd);
    end

    s3_dout_d = '0;
    s3_sat_d  = 1'b0;
    if (s2_mode_q) begin
      s3_dout_d = {{(32-INT_W){m1_res[INT_W-1]}}, m1_res};
      s3_sat_d  = m1_sat;
    end else if (s2_m0_mag_q != '0) begin
      s3_dout_d = {s2_m0_sign_q, m0_exp, m0_man};
    end
  end

  // Saturation counter sticks at all-ones.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (vld_q[LAT-1] && s3_sat_q && (sat_cnt_q != 8'hFF)) sat_cnt_d = sat_cnt_q + 8'd1;
  end

  // Pipeline registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q        <= '0;
      s1_mode_q    <= 1'b0;
      s1_tag_q     <= '0;
      s1_din_q     <= '0;
      s2_mode_q    <= 1'b0;
      s2_tag_q     <= '0;
      s2_m0_sign_q <= 1'b0;
      s2_m0_mag_q  <= '0;
      s2_m0_msb_q  <= '0;
      s2_m1_sign_q <= 1'b0;
      s2_m1_nan_q  <= 1'b0;
      s2_m1_ovf_q  <= 1'b0;
      s2_m1_zero_q <= 1'b0;
      s2_m1_sig_q  <= '0;
      s2_m1_sh_q   <= '0;
      s3_mode_q    <= 1'b0;
      s3_tag_q     <= '0;
      s3_dout_q    <= '0;
      s3_sat_q     <= 1'b0;
    end else begin
      vld_q        <= vld_d;
      s1_mode_q    <= mode;
      s1_tag_q     <= tag_i;
      s1_din_q     <= din;
      s2_mode_q    <= s1_mode_q;
      s2_tag_q     <= s1_tag_q;
      s2_m0_sign_q <= s2_m0_sign_d;
      s2_m0_mag_q  <= s2_m0_mag_d;
      s2_m0_msb_q  <= s2_m0_msb_d;
      s2_m1_sign_q <= s2_m1_sign_d;
      s2_m1_nan_q  <= s2_m1_nan_d;
      s2_m1_ovf_q  <= s2_m1_ovf_d;
      s2_m1_zero_q <= s2_m1_zero_d;
      s2_m1_sig_q  <= s2_m1_sig_d;
      s2_m1_sh_q   <= s2_m1_sh_d;
      s3_mode_q    <= s2_mode_q;
      s3_tag_q     <= s2_tag_q;
      s3_dout_q    <= s3_dout_d;
      s3_sat_q     <= s3_sat_d;
    end
  end

  // Output stage: payload updates only with a valid result, otherwise holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      srdyo_q   <= 1'b0;
      dout_q    <= '0;
      tag_o_q   <= '0;
      mode_o_q  <= 1'b0;
      sat_o_q   <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      srdyo_q   <= vld_q[LAT-1];
      sat_cnt_q <= sat_cnt_d;
      if (vld_q[LAT-1]) begin
        dout_q   <= s3_dout_q;
        tag_o_q  <= s3_tag_q;
        mode_o_q <= s3_mode_q;
        sat_o_q  <= s3_sat_q;
      end
    end
  end

  assign srdyo   = srdyo_q;
  assign dout    = dout_q;
  assign tag_o   = tag_o_q;
  assign mode_o  = mode_o_q;
  assign sat_o   = sat_o_q;
  assign sat_cnt = sat_cnt_q;

endmodule
